// File: rtl/rl_ram_1r1w_stream_reader.sv
// Purpose: walks len consecutive RAM addresses from base and streams the words out with last marking.
// Latency: start in cycle 0 -> first raddr in cycle 1 -> first tvalid in cycle 3; then 1 word/cycle.
// Backpressure: a 2-entry skid buffer holds RAM data; reads stall once buffer + in-flight reach 2.
module rl_ram_1r1w_stream_reader #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [ABITS:0]   len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ABITS-1:0] raddr_o,
  input  logic [DBITS-1:0] rdata_i,
  output logic             tvalid_o,
  input  logic             tready_i,
  output logic [DBITS-1:0] tdata_o,
  output logic             tlast_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [ABITS-1:0] r_base;
  logic [ABITS-1:0] r_raddr;
  logic [ABITS:0]   r_len;
  logic [ABITS:0]   r_issued;
  logic             r_inflight;
  logic             r_infl_last;
  logic             r_busy;
  logic             r_done;

  logic [DBITS-1:0] r_buf_dat [2];
  logic [1:0]       r_buf_last;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_cnt;

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic             w_issue_last;
  logic             w_final;
  logic [2:0]       w_occ;
  logic [ABITS:0]   w_issued_inc;
  logic [ABITS-1:0] w_raddr_next;

  // Issue decision: read only while words remain and the buffer can absorb the result.
  always_comb begin
    w_pop        = tvalid_o & tready_i;
    w_push       = r_inflight;
    w_final      = w_pop & tlast_o;
    // pop only happens with r_cnt>=1, so this never underflows
    w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issued_inc = r_issued + {{ABITS{1'b0}}, 1'b1};
    w_issue_last = (w_issued_inc == r_len);
    // address arithmetic is ABITS wide, so it wraps naturally past the top of the RAM
    w_raddr_next = r_base + r_issued[ABITS-1:0];
    w_issue      = (r_state == S_RUN) && !abort_i && (r_issued != r_len) && (w_occ < 3'd2);
  end

  assign raddr_o  = w_issue ? w_raddr_next : r_raddr;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign tvalid_o = (r_cnt != 2'd0);
  assign tdata_o  = r_buf_dat[r_rd_ptr];
  assign tlast_o  = r_buf_last[r_rd_ptr];

  // Control FSM: transfer bookkeeping, in-flight tracking and registered busy/done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_raddr     <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_last <= w_issue & w_issue_last;
      if (w_issue) begin
        r_issued <= w_issued_inc;
        r_raddr  <= w_raddr_next;
      end
      if (abort_i) begin
        // abort wins over start and over a final handshake; no done pulse
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_base   <= base_i;
              r_len    <= len_i;
              r_issued <= '0;
              if (len_i != '0) begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_final) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Skid buffer: captures RAM data the cycle after each issue, drains on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_dat[i] <= '0;
      end
      r_buf_last <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_cnt      <= '0;
    end else if (abort_i) begin
      // flush; a read still in flight is dropped because r_inflight clears too
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // on a full buffer with push+pop, the tail slot is the head being popped
      if (w_push) begin
        r_buf_dat[r_wr_ptr]  <= rdata_i;
        r_buf_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
